dmux8way_deserializer: RTL and testbench

- Serial-to-parallel collector; the inverse of the 8-way bit mux path.
- A slot counter acts as the demux select. Each accepted serial bit is written into exactly one slot of an 8-bit staging word: slot 0 first, so bit k lands in word[k].
- A completed word is presented on a valid/ready output register.
- Sits on the receive side, feeding parallel consumers (register file, decoder) from a 1-bit link.

---
 rtl/dmux_pkg.sv | 28 ++
 rtl/dmux8way.sv | 23 ++
 rtl/dmux8way_deserializer.sv | 110 +++++++++++
 tb/tb_dmux8way_deserializer.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/dmux_pkg.sv
// Shared definitions for the serial-to-parallel collector and its mux-side twin.
//   WIDTH_DEFAULT : default word width in bits
//   sel_width()   : slot-select width derived from a word width
//   out_state_e   : output register occupancy (EMPTY / FULL)
//   onehot()      : slot index -> one-hot vector, truncated by the caller
package dmux_pkg;

  localparam int WIDTH_DEFAULT = 8;
  localparam int MAX_WIDTH     = 256;
  localparam int MAX_SEL_W     = 8;

  function automatic int sel_width(input int width);
    return $clog2(width);
  endfunction

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

  function automatic logic [MAX_WIDTH-1:0] onehot(input logic [MAX_SEL_W-1:0] sel);
    logic [MAX_WIDTH-1:0] r;
    r      = '0;
    r[sel] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/dmux8way.sv
// Combinational 1-to-WIDTH demux producing the staging write enables.
//   enable : write one slot this cycle
//   slot   : slot to write
//   we     : one-hot write-enable vector, all zero when enable is low
module dmux8way
  import dmux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int SEL_W = sel_width(WIDTH)
) (
  input  logic             enable,
  input  logic [SEL_W-1:0] slot,
  output logic [WIDTH-1:0] we
);

  // NOTE: every output of a combinational block is assigned on every path;
  // a path that leaves it untouched would infer a latch.
  always_comb begin
    we = '0;
    if (enable) we = WIDTH'(onehot(MAX_SEL_W'(slot)));
  end

endmodule

// File: rtl/dmux8way_deserializer.sv
// Serial-to-parallel collector: bit k of each word lands in word[k].
//   clk, reset            : rising-edge clock, synchronous active-high reset
//   in_valid, in_bit      : serial input, one bit per accepted cycle
//   flush                 : discard the partial word (in_valid ignored)
//   clr_overrun           : clear the sticky overrun flag
//   out_ready             : consumer takes out_word
//   out_word, out_valid   : completed word and its valid flag
//   overrun               : sticky, a completed word was dropped
//   slot, busy            : next slot to write; partial word in progress
module dmux8way_deserializer
  import dmux_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEFAULT,
  localparam int SEL_W = sel_width(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             flush,
  input  logic             clr_overrun,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_word,
  output logic             out_valid,
  output logic             overrun,
  output logic [SEL_W-1:0] slot,
  output logic             busy
);

  logic             accept;
  logic             complete;
  logic [WIDTH-1:0] we;
  logic [WIDTH-1:0] staging;
  logic [WIDTH-1:0] done_word;
  out_state_e       state;

  assign accept   = in_valid & ~flush;
  assign complete = accept & (slot == SEL_W'(WIDTH - 1));
  assign busy     = (slot != '0);

  // The last bit goes straight into the delivered word; staging never holds it.
  always_comb begin
    done_word            = staging;
    done_word[WIDTH-1]   = in_bit;
  end

  dmux8way #(
    .WIDTH (WIDTH),
    .SEL_W (SEL_W)
  ) u_demux (
    .enable (accept),
    .slot   (slot),
    .we     (we)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  // NOTE: staging is reset explicitly; a stale partial word after reset would
  // corrupt the first word assembled.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot    <= '0;
      staging <= '0;
    end else if (flush) begin
      slot    <= '0;
      staging <= '0;
    end else if (accept) begin
      slot <= slot + SEL_W'(1);
      if (complete) staging <= '0;
      else          staging <= (staging & ~we) | (we & {WIDTH{in_bit}});
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EMPTY;
      out_word  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      // Set beats clear when both happen on one edge.
      if (state == FULL && complete && !out_ready) overrun <= 1'b1;
      else if (clr_overrun)                        overrun <= 1'b0;

      case (state)
        EMPTY: begin
          if (complete) begin
            state     <= FULL;
            out_word  <= done_word;
            out_valid <= 1'b1;
          end
        end
        FULL: begin
          if (complete) begin
            // Ready: back-to-back handoff; not ready: new word is dropped.
            if (out_ready) out_word <= done_word;
          end else if (out_ready) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmux8way_deserializer.sv
// Self-checking bench: directed scenarios plus randomized traffic, all checked
// against a queue-based reference model of the collector.
module tb_dmux8way_deserializer;

  localparam int W  = 8;
  localparam int SW = $clog2(W);

  logic          clk = 1'b0;
  logic          reset, in_valid, in_bit, flush, clr_overrun, out_ready;
  logic [W-1:0]  out_word;
  logic          out_valid, overrun, busy;
  logic [SW-1:0] slot;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state
  bit           pend[$];
  bit           m_valid;
  bit [W-1:0]   m_word;
  bit           m_over;

  always #5 clk = ~clk;

  dmux8way_deserializer #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .flush       (flush),
    .clr_overrun (clr_overrun),
    .out_ready   (out_ready),
    .out_word    (out_word),
    .out_valid   (out_valid),
    .overrun     (overrun),
    .slot        (slot),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle, advance the model, then compare every output after the edge.
  task automatic step(input bit iv, input bit ib, input bit fl, input bit clr,
                      input bit rdy, input bit rst);
    bit         comp;
    bit [W-1:0] w;
    in_valid = iv; in_bit = ib; flush = fl; clr_overrun = clr;
    out_ready = rdy; reset = rst;
    comp = 0;
    w = '0;
    if (rst) begin
      pend.delete();
      m_valid = 0; m_word = '0; m_over = 0;
    end else begin
      if (fl) pend.delete();
      else if (iv) begin
        pend.push_back(ib);
        if (pend.size() == W) begin
          comp = 1;
          for (int k = 0; k < W; k++) w[k] = pend[k];
          pend.delete();
        end
      end
      if (m_valid) begin
        if (comp) begin
          if (rdy) m_word = w;
          else     m_over = 1;
        end else if (rdy) m_valid = 0;
        if (!(comp && !rdy) && clr) m_over = 0;
      end else begin
        if (comp) begin m_valid = 1; m_word = w; end
        if (clr) m_over = 0;
      end
    end
    @(posedge clk);
    #1;
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("out_word",  32'(out_word),  32'(m_word));
    check("overrun",   32'(overrun),   32'(m_over));
    check("slot",      32'(slot),      32'(pend.size()));
    check("busy",      32'(busy),      32'(pend.size() != 0));
  endtask

  task automatic send_bits(input logic [W-1:0] word, input int n, input bit rdy);
    for (int k = 0; k < n; k++) step(1, word[k], 0, 0, rdy, 0);
  endtask

  initial begin
    logic [W-1:0] b2;
    in_valid = 0; in_bit = 0; flush = 0; clr_overrun = 0; out_ready = 0; reset = 1;
    @(posedge clk); #1;
    step(0, 0, 0, 0, 0, 1);
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_slot",  32'(slot),      32'd0);

    // 1: single word, consumer always ready
    send_bits(8'h01, W, 1);
    check("t1_word",  32'(out_word),  32'h01);
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_slot",  32'(slot),      32'd0);
    step(0, 0, 0, 0, 1, 0);
    check("t1_pulse", 32'(out_valid), 32'd0);

    // 2: gaps inside a word
    b2 = 8'b10011010;
    for (int k = 0; k < W; k++) begin
      step(1, b2[k], 0, 0, 1, 0);
      if (k == 1 || k == 4) begin
        step(0, 0, 0, 0, 1, 0);
        check("t2_gap_slot", 32'(slot), 32'(k + 1));
        check("t2_busy",     32'(busy), 32'd1);
      end
    end
    check("t2_word", 32'(out_word), 32'h9A);
    step(0, 0, 0, 0, 1, 0);

    // 3: overrun while the consumer stalls
    send_bits(8'hA5, W, 0);
    send_bits(8'h3C, W, 0);
    check("t3_word", 32'(out_word), 32'hA5);
    check("t3_over", 32'(overrun),  32'd1);
    step(0, 0, 0, 1, 0, 0);
    check("t3_clr",  32'(overrun),  32'd0);

    // 4: back-to-back handoff on the completing cycle
    send_bits(8'hFF, W - 1, 0);
    step(1, 1, 0, 0, 1, 0);
    check("t4_word",  32'(out_word),  32'hFF);
    check("t4_valid", 32'(out_valid), 32'd1);
    check("t4_over",  32'(overrun),   32'd0);
    step(0, 0, 0, 0, 1, 0);

    // 5: flush drops the partial word
    send_bits(8'h1F, 5, 1);
    step(1, 1, 1, 0, 1, 0);
    check("t5_slot", 32'(slot), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    send_bits(8'h81, W, 0);
    check("t5_word", 32'(out_word), 32'h81);
    step(0, 0, 0, 0, 1, 0);

    // 6: reset mid-word
    send_bits(8'h3F, 6, 0);
    step(0, 0, 0, 0, 0, 1);
    check("t6_word",  32'(out_word),  32'h00);
    check("t6_valid", 32'(out_valid), 32'd0);
    check("t6_slot",  32'(slot),      32'd0);
    send_bits(8'h0F, W, 0);
    check("t6_new", 32'(out_word), 32'h0F);

    // Randomized traffic; flush at slot WIDTH-1 and set/clear collisions arise naturally.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 3) != 0), 1'($urandom),
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 499) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
